sysid_check_ctrl: RTL
=====================

Name: sysid_check_ctrl

Overview:
- Boot-time and on-demand verifier for the system-ID slave.
- Acts as an Avalon-MM read master toward the sysid control_slave.
- Reads the ID word (address 0), then the timestamp word (address 1), and compares both against build-time expected values.
- Publishes pass/fail and timeout status to reset/boot logic and to a CPU-visible status register, so a mismatched FPGA image or software image is flagged before the Nios core proceeds.

Parameters:
- EXP_ID, 32'h0000_0000, expected value at address 0.
- EXP_TIMESTAMP, 32'h5A30_08F9, expected value at address 1.
- TIMEOUT, 8'd255, max consecutive waitrequest-high cycles tolerated per read; range 1..255.
- AUTO_START, 1, 1 = run one check automatically after reset release.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a check; ignored while busy.
- avm_address  out  1  0 = ID word, 1 = timestamp word.
- avm_read  out  1  Avalon read strobe.
- avm_readdata  in  32  slave read data.
- avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave.
- busy  out  1  check in progress.
- done  out  1  level; result valid, held until next accepted start.
- id_ok  out  1  captured ID equals EXP_ID.
- ts_ok  out  1  captured timestamp equals EXP_TIMESTAMP.
- timeout_err  out  1  a read exceeded TIMEOUT stall cycles.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.

Behaviour:
- Reset values: all outputs 0. id_value and ts_value are 0. FSM is in IDLE; timeout counter is 0. Reset is asynchronous.
- Reset mid-operation: FSM returns to IDLE immediately and avm_read drops asynchronously. If AUTO_START=1, the check restarts after reset release.
- FSM states: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE:
  - Go to RD_ID on start=1, or on the first clock edge after reset release if AUTO_START=1.
  - On entry to RD_ID: clear done, id_ok, ts_ok and timeout_err; set busy.
- RD_ID:
  - Drive avm_read=1, avm_address=0.
  - On an edge with avm_waitrequest=0, capture avm_readdata into id_value, clear the counter, go to RD_TS.
  - The read is held stable while waitrequest=1.
- RD_TS: same as RD_ID with avm_address=1, capturing into ts_value; go to CHECK.
- CHECK (one cycle, avm_read=0):
  - Register id_ok = (id_value==EXP_ID) and ts_ok = (ts_value==EXP_TIMESTAMP).
  - Go to DONE.
- DONE:
  - done=1, busy=0.
  - start=1 goes directly to RD_ID (restart); otherwise stay in DONE.
- Timeout:
  - In RD_ID/RD_TS, count edges with waitrequest=1; the counter saturates at 8 bits.
  - When the count reaches TIMEOUT while waitrequest is still 1, deassert avm_read and go to DONE with timeout_err=1, id_ok=0, ts_ok=0.
  - id_value/ts_value keep whatever was captured before the abort.
- start while busy is ignored; no queuing.
- Latency with waitrequest=0, start sampled high at edge E0:
  - RD_ID during cycle E0..E1.
  - RD_TS during E1..E2.
  - CHECK during E2..E3.
  - done=1 from E3, so done rises 3 cycles after start.
- Each extra stall cycle adds one cycle to latency.
- avm_read is never high in IDLE, CHECK or DONE.
- avm_address changes only while avm_read=0 or on an accepted transfer.

Decomposition:
- Shared package sysid_pkg holds:
  - FSM state enum.
  - Address constants SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1.
  - Default expected-value constants.
- The timeout counter is a natural sub-module: stall_timer (enable, clear, terminal-count output).

Test Plan:
- Reset with AUTO_START=1, zero-wait slave returning 0 / 32'h5A3008F9 -> done=1 three cycles after reset release; id_ok=1, ts_ok=1, timeout_err=0.
- Slave returns timestamp 32'h5A3008F8 -> ts_ok=0, id_ok=1, ts_value=32'h5A3008F8.
- Waitrequest=1 for 4 cycles on the ID read with TIMEOUT=255 -> address 0 held stable throughout, done at 7 cycles, both ok flags=1.
- Waitrequest stuck 1 with TIMEOUT=8 -> avm_read drops after 8 stall cycles; done=1, timeout_err=1, both ok flags=0.
- start pulse during RD_TS -> ignored, single pass. start in DONE -> flags clear on the next cycle and the check reruns.
- reset_n asserted during RD_TS -> avm_read=0 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM states, sysid register
// addresses and default expected values.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXP_ID_DEF  = 32'h0000_0000;
    localparam logic [31:0] SYSID_EXP_TS_DEF  = 32'h5A30_08F9;
    localparam logic [7:0]  SYSID_TIMEOUT_DEF = 8'd255;

endpackage

// File: rtl/stall_timer.sv
// Saturating count of consecutive stalled read edges; expire flags the edge
// on which the LIMIT-th stall is being taken.
module stall_timer #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    logic [7:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign expire = enable && (count >= (LIMIT - 8'd1));

endmodule

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// compares them against build-time expected values.
module sysid_check_ctrl
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXP_ID        = SYSID_EXP_ID_DEF,
    parameter logic [31:0] EXP_TIMESTAMP = SYSID_EXP_TS_DEF,
    parameter logic [7:0]  TIMEOUT       = SYSID_TIMEOUT_DEF,
    parameter bit          AUTO_START    = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t state;
    logic   auto_pend;
    logic   in_read;
    logic   go;
    logic   expire;

    assign in_read = (state == RD_ID) || (state == RD_TS);
    assign go      = ((state == IDLE) && (start || auto_pend)) ||
                     ((state == DONE) && start);

    // Counter restarts on every accepted transfer so each read gets its own budget.
    stall_timer #(
        .LIMIT(TIMEOUT)
    ) u_stall_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .enable (in_read && avm_waitrequest),
        .clear  (!in_read || !avm_waitrequest),
        .expire (expire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            auto_pend   <= AUTO_START;
            avm_address <= SYSID_ADDR_ID;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else if (go) begin
            state       <= RD_ID;
            auto_pend   <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            avm_read    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
        end else if (expire) begin
            // Abort keeps whatever words were already captured.
            state       <= DONE;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b1;
        end else begin
            case (state)
                RD_ID: begin
                    if (!avm_waitrequest) begin
                        id_value    <= avm_readdata;
                        avm_address <= SYSID_ADDR_TS;
                        state       <= RD_TS;
                    end
                end
                RD_TS: begin
                    if (!avm_waitrequest) begin
                        ts_value <= avm_readdata;
                        avm_read <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    id_ok <= (id_value == EXP_ID);
                    ts_ok <= (ts_value == EXP_TIMESTAMP);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
